// File: rtl/rt_delay_pkg.sv
// Shared definitions for the runtime delay-line select ramp controller.
package rt_delay_pkg;

  // Default width of the delay-line select.
  localparam int DELAY_W_DFLT   = 5;
  // Highest select the ramp may drive. 31 is reserved for pass-through.
  localparam int MAX_DELAY_DFLT = 30;
  // Delay-line select code that bypasses the line (zero delay).
  localparam int PASS_THRU_SEL  = 31;

  // Ramp controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } rt_state_e;

  // Plain-vector state codes for the legacy-style state register.
  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_WAIT = ST_WAIT;
  localparam logic [1:0] S_DONE = ST_DONE;

endpackage

// File: rtl/rt_step_timer.sv
// Reloadable interval down-counter. o_tick marks an enabled cycle at zero count.
module rt_step_timer
  import rt_delay_pkg::*;
#(
  parameter int STEP_INTERVAL = 16,
  parameter int CNT_W         = $clog2(STEP_INTERVAL + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_load,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEP_INTERVAL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [CNT_W-1:0] r_cnt;

  // Reload has priority; otherwise count down while enabled, saturating at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= CNT_ZERO;
    end else if (i_load) begin
      r_cnt <= CNT_LOAD;
    end else if (i_en && (r_cnt != CNT_ZERO)) begin
      r_cnt <= r_cnt - CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_tick = i_en & (r_cnt == CNT_ZERO);

endmodule

// File: rtl/rt_delay_ramp_ctrl.sv
// Ramps the delay-line select one tap at a time toward an accepted target.
module rt_delay_ramp_ctrl
  import rt_delay_pkg::*;
#(
  parameter int DELAY_W       = DELAY_W_DFLT,
  parameter int MAX_DELAY     = MAX_DELAY_DFLT,
  parameter int INITIAL_DELAY = 1,
  parameter int STEP_INTERVAL = 16,
  parameter int CNT_W         = $clog2(STEP_INTERVAL + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               tgt_valid,
  output logic               tgt_ready,
  input  logic [DELAY_W-1:0] tgt_delay,
  output logic [DELAY_W-1:0] delay,
  output logic               busy,
  output logic               done,
  output logic               clamp_err
);

  localparam logic [DELAY_W-1:0] MAX_SEL  = DELAY_W'(MAX_DELAY);
  localparam logic [DELAY_W-1:0] INIT_SEL = DELAY_W'(INITIAL_DELAY);
  localparam logic [DELAY_W-1:0] ONE_SEL  = DELAY_W'(1);

  logic [1:0]         r_state;
  logic [DELAY_W-1:0] r_delay;
  logic [DELAY_W-1:0] r_target;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;
  logic               r_clamp_err;

  logic [1:0]         w_state_nxt;
  logic [DELAY_W-1:0] w_delay_nxt;
  logic [DELAY_W-1:0] w_target_nxt;
  logic               w_clamp_nxt;
  logic               w_load;
  logic               w_tick;
  logic               w_tmr_en;
  logic               w_over;
  logic [DELAY_W-1:0] w_tgt_clamped;
  logic [DELAY_W-1:0] w_delay_step;

  // Limit the requested target to the highest legal select and flag overshoot.
  always_comb begin
    if (tgt_delay > MAX_SEL) begin
      w_over        = 1'b1;
      w_tgt_clamped = MAX_SEL;
    end else begin
      w_over        = 1'b0;
      w_tgt_clamped = tgt_delay;
    end
  end

  // Next select one tap toward the target; never moves past it, so no wrap.
  always_comb begin
    if (r_target > r_delay) begin
      w_delay_step = r_delay + ONE_SEL;
    end else if (r_target < r_delay) begin
      w_delay_step = r_delay - ONE_SEL;
    end else begin
      w_delay_step = r_delay;
    end
  end

  // The interval timer only runs while a ramp is waiting for its next step.
  assign w_tmr_en = en & (r_state == S_WAIT);

  rt_step_timer #(
    .STEP_INTERVAL (STEP_INTERVAL),
    .CNT_W         (CNT_W)
  ) u_step_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_tmr_en),
    .i_load (w_load),
    .o_tick (w_tick)
  );

  // Ramp sequencing: accept in IDLE, step on timer ticks, pulse DONE once.
  always_comb begin
    w_state_nxt  = r_state;
    w_delay_nxt  = r_delay;
    w_target_nxt = r_target;
    w_clamp_nxt  = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (tgt_valid) begin
          w_target_nxt = w_tgt_clamped;
          w_clamp_nxt  = w_over;
          if (w_tgt_clamped == r_delay) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_WAIT;
            w_load      = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (w_tick) begin
          w_delay_nxt = w_delay_step;
          if (w_delay_step == r_target) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_WAIT;
            w_load      = 1'b1;
          end
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, select and status registers; status is decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_delay     <= INIT_SEL;
      r_target    <= INIT_SEL;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_clamp_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_delay     <= w_delay_nxt;
      r_target    <= w_target_nxt;
      r_ready     <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt == S_WAIT);
      r_done      <= (w_state_nxt == S_DONE);
      r_clamp_err <= w_clamp_nxt;
    end
  end

  assign delay     = r_delay;
  assign tgt_ready = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign clamp_err = r_clamp_err;

endmodule
